// File: rtl/display_scan_ctrl.sv
// Four-digit seven-segment scan controller with a small register window on the lisp_core bus.
// Optional blink support (CTRL bit4) is compiled in when DISPLAY_SCAN_BLINK_EN is defined.
module display_scan_ctrl #(
    parameter int BASE_INDEX  = 8,
    parameter int SCAN_DIV    = 1024,
    parameter int DEAD_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [6:0]  register_index,
    input  logic        register_read,
    input  logic        register_write,
    input  logic [15:0] register_write_value,
    output logic [15:0] register_read_value,
    output logic [6:0]  seg_out,
    output logic [3:0]  digit_sel
);

    localparam int CNT_MAX = (SCAN_DIV > DEAD_CYCLES) ? SCAN_DIV : DEAD_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int SLICE   = SCAN_DIV / 8;

    typedef enum logic [1:0] {IDLE, DRIVE, BLANK} scan_state_t;

    scan_state_t      r_state;
    scan_state_t      w_nextState;
    logic [6:0]       r_digit [4];
    logic             r_enable;
    logic [2:0]       r_bright;
`ifdef DISPLAY_SCAN_BLINK_EN
    logic             r_blink;
`endif
    logic [13:0]      r_frame;
    logic [1:0]       r_digitIdx;
    logic [CNT_W-1:0] r_slotCnt;
    logic [6:0]       r_pattern;
    logic [15:0]      r_readValue;

    logic [6:0]       w_offset;
    logic             w_inMap;
    logic             w_enableNext;
    logic             w_latch;
    logic             w_frameInc;
    logic [1:0]       w_digitIdxNext;
    logic [CNT_W-1:0] w_slotCntNext;
    logic [CNT_W-1:0] w_litLimit;
    logic [15:0]      w_readMux;
    logic             w_unused;

    assign w_offset = register_index - 7'(BASE_INDEX);
    assign w_inMap  = (register_index >= 7'(BASE_INDEX)) && (w_offset < 7'd6);
    assign w_unused = &{1'b0, register_write_value[15:7]};

    // Scan decisions look at the enable value being written this edge, so a CTRL write acts next cycle.
    assign w_enableNext = (register_write && w_inMap && (w_offset == 7'd4))
                        ? register_write_value[0] : r_enable;
    assign w_litLimit   = CNT_W'((int'(r_bright) + 1) * SLICE);

    assign register_read_value = r_readValue;

    always_comb begin
        w_readMux = '0;
        if (w_inMap) begin
            case (w_offset[2:0])
                3'd0, 3'd1, 3'd2, 3'd3: w_readMux[6:0] = r_digit[w_offset[1:0]];
                3'd4: begin
                    w_readMux[3:0] = {r_bright, r_enable};
`ifdef DISPLAY_SCAN_BLINK_EN
                    w_readMux[4] = r_blink;
`endif
                end
                3'd5:    w_readMux = {r_frame, r_digitIdx};
                default: w_readMux = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) r_digit[i] <= '0;
            r_enable    <= 1'b0;
            r_bright    <= '0;
`ifdef DISPLAY_SCAN_BLINK_EN
            r_blink     <= 1'b0;
`endif
            r_readValue <= '0;
        end else begin
            if (register_read) r_readValue <= w_readMux;
            if (register_write && w_inMap) begin
                case (w_offset[2:0])
                    3'd0, 3'd1, 3'd2, 3'd3: r_digit[w_offset[1:0]] <= register_write_value[6:0];
                    3'd4: begin
                        r_enable <= register_write_value[0];
                        r_bright <= register_write_value[3:1];
`ifdef DISPLAY_SCAN_BLINK_EN
                        r_blink  <= register_write_value[4];
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        w_nextState    = r_state;
        w_slotCntNext  = r_slotCnt;
        w_digitIdxNext = r_digitIdx;
        w_latch        = 1'b0;
        w_frameInc     = 1'b0;
        seg_out        = '0;
        digit_sel      = '0;
        if (!w_enableNext) begin
            w_nextState    = IDLE;
            w_slotCntNext  = '0;
            w_digitIdxNext = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_nextState    = DRIVE;
                    w_slotCntNext  = '0;
                    w_digitIdxNext = '0;
                    w_latch        = 1'b1;
                end
                DRIVE: begin
                    if (r_slotCnt == CNT_W'(SCAN_DIV - 1)) begin
                        w_nextState   = BLANK;
                        w_slotCntNext = '0;
                    end else begin
                        w_slotCntNext = r_slotCnt + 1'b1;
                    end
                end
                BLANK: begin
                    if (r_slotCnt == CNT_W'(DEAD_CYCLES - 1)) begin
                        w_nextState    = DRIVE;
                        w_slotCntNext  = '0;
                        w_digitIdxNext = r_digitIdx + 2'd1;
                        w_latch        = 1'b1;
                        w_frameInc     = (r_digitIdx == 2'd3);
                    end else begin
                        w_slotCntNext = r_slotCnt + 1'b1;
                    end
                end
                default: w_nextState = IDLE;
            endcase
        end
        if (r_state == DRIVE) begin
            digit_sel = 4'b0001 << r_digitIdx;
            if (r_slotCnt < w_litLimit) seg_out = r_pattern;
`ifdef DISPLAY_SCAN_BLINK_EN
            if (r_blink && r_frame[7]) seg_out = '0;
`endif
        end
    end

    // The pattern is captured at slot entry so mid-slot digit writes only show on the next slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_slotCnt  <= '0;
            r_digitIdx <= '0;
            r_pattern  <= '0;
            r_frame    <= '0;
        end else begin
            r_state    <= w_nextState;
            r_slotCnt  <= w_slotCntNext;
            r_digitIdx <= w_digitIdxNext;
            if (w_latch) r_pattern <= r_digit[w_digitIdxNext];
            if (w_frameInc) r_frame <= r_frame + 14'd1;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl: directed scenarios plus randomized bus traffic
// compared every cycle against a time-based behavioural model of the scan sequence.
module tb_display_scan_ctrl;

    localparam int SCAN_DIV = 16;
    localparam int DEAD     = 2;
    localparam int BASE     = 8;
    localparam int PERIOD   = SCAN_DIV + DEAD;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [6:0]  register_index = '0;
    logic        register_read = 1'b0;
    logic        register_write = 1'b0;
    logic [15:0] register_write_value = '0;
    logic [15:0] register_read_value;
    logic [6:0]  seg_out;
    logic [3:0]  digit_sel;

    int errors = 0;
    int checks = 0;
    logic [15:0] rdValue;

    display_scan_ctrl #(.BASE_INDEX(BASE), .SCAN_DIV(SCAN_DIV), .DEAD_CYCLES(DEAD)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .register_index(register_index),
        .register_read(register_read),
        .register_write(register_write),
        .register_write_value(register_write_value),
        .register_read_value(register_read_value),
        .seg_out(seg_out),
        .digit_sel(digit_sel)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: scan position is derived from the number of cycles since enable took effect.
    logic [6:0]  mDigit [4];
    logic        mEnable;
    logic [2:0]  mBright;
    logic        mBlink;
    logic        mActive;
    int          mT;
    int          mFrameBase;
    logic [6:0]  mLatched;
    logic [15:0] mRead;
    int          mRel;
    logic        mNewEn;

    function automatic int frameNow();
        return mActive ? (mFrameBase + (mT / PERIOD) / 4) % 16384 : mFrameBase;
    endfunction

    function automatic int digitNow();
        return mActive ? (mT / PERIOD) % 4 : 0;
    endfunction

    function automatic logic [15:0] modelRead(input logic [6:0] idx);
        int rel;
        rel = int'(idx) - BASE;
        case (rel)
            0, 1, 2, 3: return {9'b0, mDigit[rel]};
            4:          return {11'b0, mBlink, mBright, mEnable};
            5:          return 16'((frameNow() << 2) | digitNow());
            default:    return 16'h0000;
        endcase
    endfunction

    function automatic logic [3:0] expDigitSel();
        if (mActive && (mT % PERIOD) < SCAN_DIV) return 4'(1 << ((mT / PERIOD) % 4));
        return 4'b0000;
    endfunction

    function automatic logic [6:0] expSeg();
        if (!mActive || (mT % PERIOD) >= SCAN_DIV) return 7'h00;
        if ((mT % PERIOD) >= (int'(mBright) + 1) * SCAN_DIV / 8) return 7'h00;
        if (mBlink && ((frameNow() >> 7) & 1) == 1) return 7'h00;
        return mLatched;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) mDigit[i] = '0;
            mEnable = 1'b0; mBright = '0; mBlink = 1'b0; mActive = 1'b0;
            mT = 0; mFrameBase = 0; mLatched = '0; mRead = '0;
        end else begin
            mRel = int'(register_index) - BASE;
            if (register_read) mRead = modelRead(register_index);
            mNewEn = (register_write && mRel == 4) ? register_write_value[0] : mEnable;
            if (!mNewEn) begin
                if (mActive) mFrameBase = frameNow();
                mActive = 1'b0;
                mT = 0;
            end else if (!mActive) begin
                mActive = 1'b1;
                mT = 0;
                mLatched = mDigit[0];
            end else begin
                mT++;
                if (mT % PERIOD == 0) mLatched = mDigit[(mT / PERIOD) % 4];
            end
            if (register_write) begin
                case (mRel)
                    0, 1, 2, 3: mDigit[mRel] = register_write_value[6:0];
                    4: begin
                        mEnable = register_write_value[0];
                        mBright = register_write_value[3:1];
`ifdef DISPLAY_SCAN_BLINK_EN
                        mBlink  = register_write_value[4];
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            checkOutput("model_digit_sel", {12'b0, digit_sel}, {12'b0, expDigitSel()});
            checkOutput("model_seg_out", {9'b0, seg_out}, {9'b0, expSeg()});
            checkOutput("model_read_value", register_read_value, mRead);
        end
    end

    task automatic applyStimulus(input bit wr, input bit rd, input int idx, input logic [15:0] val);
        @(negedge clk);
        register_write       = wr;
        register_read        = rd;
        register_index       = 7'(idx);
        register_write_value = val;
        @(negedge clk);
        register_write = 1'b0;
        register_read  = 1'b0;
    endtask

    task automatic readReg(input int idx, output logic [15:0] value);
        applyStimulus(1'b0, 1'b1, idx, 16'h0000);
        value = register_read_value;
    endtask

    task automatic resetDut();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        checkOutput("reset_sel", {12'b0, digit_sel}, 16'h0000);
        checkOutput("reset_seg", {9'b0, seg_out}, 16'h0000);
        checkOutput("reset_rdata", register_read_value, 16'h0000);
        reset_n = 1'b1;

        // Full-brightness scan of digit0 then blank then digit1.
        resetDut();
        applyStimulus(1'b1, 1'b0, BASE + 0, 16'h003F);
        applyStimulus(1'b1, 1'b0, BASE + 4, 16'h000F);
        checkOutput("scan_t0_sel", {12'b0, digit_sel}, 16'h0001);
        checkOutput("scan_t0_seg", {9'b0, seg_out}, 16'h003F);
        repeat (15) @(negedge clk);
        checkOutput("scan_t15_sel", {12'b0, digit_sel}, 16'h0001);
        checkOutput("scan_t15_seg", {9'b0, seg_out}, 16'h003F);
        @(negedge clk);
        checkOutput("scan_t16_sel", {12'b0, digit_sel}, 16'h0000);
        @(negedge clk);
        checkOutput("scan_t17_sel", {12'b0, digit_sel}, 16'h0000);
        @(negedge clk);
        checkOutput("scan_t18_sel", {12'b0, digit_sel}, 16'h0002);

        // Brightness 0: lit for SCAN_DIV/8 = 2 cycles of the slot.
        resetDut();
        applyStimulus(1'b1, 1'b0, BASE + 0, 16'h007F);
        applyStimulus(1'b1, 1'b0, BASE + 4, 16'h0001);
        checkOutput("dim_t0_seg", {9'b0, seg_out}, 16'h007F);
        @(negedge clk);
        checkOutput("dim_t1_seg", {9'b0, seg_out}, 16'h007F);
        for (int t = 2; t < 16; t++) begin
            @(negedge clk);
            checkOutput("dim_off_seg", {9'b0, seg_out}, 16'h0000);
            checkOutput("dim_off_sel", {12'b0, digit_sel}, 16'h0001);
        end

        // Four full slots advance the frame count to 1 with the digit back at 0.
        resetDut();
        applyStimulus(1'b1, 1'b0, BASE + 4, 16'h0001);
        repeat (74) @(negedge clk);
        readReg(BASE + 5, rdValue);
        checkOutput("status_frame1", rdValue, 16'h0004);
        applyStimulus(1'b1, 1'b0, BASE + 4, 16'h0000);
        readReg(BASE + 5, rdValue);
        checkOutput("status_retained", rdValue, 16'h0004);
        applyStimulus(1'b1, 1'b0, BASE + 5, 16'hFFFF);
        readReg(BASE + 5, rdValue);
        checkOutput("status_readonly", rdValue, 16'h0004);
        readReg(20, rdValue);
        checkOutput("read_out_of_map", rdValue, 16'h0000);

        // Disable mid-DRIVE.
        resetDut();
        applyStimulus(1'b1, 1'b0, BASE + 0, 16'h0055);
        applyStimulus(1'b1, 1'b0, BASE + 4, 16'h000F);
        repeat (5) @(negedge clk);
        applyStimulus(1'b1, 1'b0, BASE + 4, 16'h0000);
        checkOutput("disable_sel", {12'b0, digit_sel}, 16'h0000);
        checkOutput("disable_seg", {9'b0, seg_out}, 16'h0000);
        readReg(BASE + 5, rdValue);
        checkOutput("disable_status", rdValue, 16'h0000);

        // Simultaneous read and write returns the old value; undefined bits read 0.
        resetDut();
        applyStimulus(1'b1, 1'b0, BASE + 1, 16'h0012);
        applyStimulus(1'b1, 1'b1, BASE + 1, 16'hFF34);
        checkOutput("rw_same_cycle", register_read_value, 16'h0012);
        readReg(BASE + 1, rdValue);
        checkOutput("digit_masked", rdValue, 16'h0034);
        applyStimulus(1'b1, 1'b0, BASE + 4, 16'hFFFE);
        readReg(BASE + 4, rdValue);
`ifdef DISPLAY_SCAN_BLINK_EN
        checkOutput("ctrl_masked", rdValue, 16'h001E);
`else
        checkOutput("ctrl_masked", rdValue, 16'h000E);
`endif

        // Asynchronous reset mid-slot.
        resetDut();
        for (int d = 0; d < 4; d++) applyStimulus(1'b1, 1'b0, BASE + d, 16'(7'h11 * (d + 1)));
        applyStimulus(1'b1, 1'b0, BASE + 4, 16'h000F);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("async_reset_sel", {12'b0, digit_sel}, 16'h0000);
        checkOutput("async_reset_seg", {9'b0, seg_out}, 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            readReg(BASE + i, rdValue);
            checkOutput("post_reset_reg", rdValue, 16'h0000);
        end
        checkOutput("post_reset_idle", {12'b0, digit_sel}, 16'h0000);

        // Randomized bus traffic with the scan running; the model checks every cycle.
        resetDut();
        applyStimulus(1'b1, 1'b0, BASE + 4, 16'h0003);
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            register_write       = ($urandom_range(0, 99) < 8);
            register_read        = ($urandom_range(0, 3) == 0);
            register_index       = 7'($urandom_range(BASE - 2, BASE + 8));
            register_write_value = 16'($urandom);
            if (int'(register_index) == BASE + 4)
                register_write_value[0] = ($urandom_range(0, 9) != 0);
        end
        @(negedge clk);
        register_write = 1'b0;
        register_read  = 1'b0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 Parameter BASE_INDEX, default 8, first register index decoded by this block.
REQ-002 Parameter SCAN_DIV, default 1024, clocks per digit drive slot; multiple of 8, >= 16.
REQ-003 Parameter DEAD_CYCLES, default 4, clocks of all-digits-off between slots; >= 1.
REQ-004 clk  input  1  single system clock, all state on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 register_index  input  7  register bus index from lisp_core.
REQ-007 register_read  input  1  read strobe, one cycle.
REQ-008 register_write  input  1  write strobe, one cycle.
REQ-009 register_write_value  input  16  write data.
REQ-010 register_read_value  output  16  read data, registered.
REQ-011 seg_out  output  7  segment drive for the selected digit, 1 = segment lit.
REQ-012 digit_sel  output  4  one-hot digit enable, bit n = digit n, 1 = active.

Function
REQ-013 Register map: BASE+0..BASE+3 = digit0..digit3 patterns (bits [6:0], R/W); BASE+4 = CTRL (bit0 enable, bits[3:1] brightness, R/W); BASE+5 = STATUS (bits[1:0] current digit, bits[15:2] frame count, read-only).
REQ-014 Write with index in map updates the register on the same clock edge; bits outside defined fields are ignored and read as 0; writes to STATUS and to indices outside BASE..BASE+5 are ignored.
REQ-015 Read: register_read_value updated one cycle after register_read; value 0 when index outside map; when register_read is low it holds its previous value.
REQ-016 Simultaneous read and write of the same index returns the pre-write value.
REQ-017 Scan FSM states: IDLE, DRIVE, BLANK.
REQ-018 IDLE: digit_sel = 0, seg_out = 0, digit index = 0; leaves to DRIVE on the cycle after CTRL.enable is written to 1.
REQ-019 On entry to DRIVE the selected digit pattern is latched; register writes during a slot take effect at the next slot.
REQ-020 DRIVE lasts exactly SCAN_DIV cycles; digit_sel is one-hot on the current digit throughout; seg_out = latched pattern while slot counter < (brightness+1)*SCAN_DIV/8, else 0.
REQ-021 DRIVE -> BLANK after SCAN_DIV cycles; BLANK lasts DEAD_CYCLES cycles with digit_sel = 0 and seg_out = 0.
REQ-022 BLANK -> DRIVE with digit index incremented modulo 4 (3 wraps to 0); frame count increments on each 3->0 wrap and wraps at 2^14-1 -> 0.
REQ-023 CTRL.enable cleared in any state: next cycle IDLE, outputs 0, digit index and slot counter 0; frame count retained.
REQ-024 Brightness 7 = segments lit for the whole slot; brightness 0 = lit for SCAN_DIV/8 cycles.

Reset
REQ-025 While reset_n low: digit registers 0, CTRL 0, frame count 0, FSM IDLE, register_read_value 0, seg_out 0, digit_sel 0.
REQ-026 Reset asserted mid-slot forces all outputs to 0 immediately (asynchronously); operation resumes only after enable is rewritten.

Configuration
REQ-027 Macro DISPLAY_SCAN_BLINK_EN defined: CTRL bit4 = blink, R/W; when 1, seg_out forced to 0 during frames whose frame count bit 7 is 1; scan timing unchanged.
REQ-028 Macro undefined: CTRL bit4 not implemented, reads 0, no blink logic present.

Verification (SCAN_DIV=16, DEAD_CYCLES=2, BASE_INDEX=8)
REQ-029 Reset, write idx 8=0x3F, idx 12=0x000F -> digit_sel 0001 for 16 cycles with seg_out 0x3F, then 0000 for 2 cycles, then 0010.
REQ-030 CTRL=0x0001 (brightness 0), digit0=0x7F -> seg_out 0x7F for 2 cycles then 0 for 14 cycles of each digit0 slot.
REQ-031 Run 4 full slots from enable -> idx 13 reads 0x0004 (frame 1, digit 0) one cycle after read strobe.
REQ-032 Write idx 12=0 mid-DRIVE -> next cycle digit_sel 0000, seg_out 0, idx 13 digit field 0.
REQ-033 Read idx 20 -> 0x0000; write idx 13=0xFFFF -> STATUS unchanged.
REQ-034 Pulse reset_n low mid-slot -> outputs 0 without clock edge; idx 8..12 read 0 after release.
